// File: rtl/permute_restore_if.sv
// Bundle between the restore block and its requester: start/operands in, restored list/status out.
// Positions are PW = $clog2(INPUTVALS)+1 bits wide so an out-of-range index can be expressed.
interface permute_restore_if #(
  parameter int INPUTVALS      = 16,
  parameter int INPUTBITWIDTHS = 32
);
  localparam int PW = $clog2(INPUTVALS) + 1;

  logic                                      restorestart;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  sorted_in;
  logic [INPUTVALS-1:0][PW-1:0]              positions_in;
  logic                                      restoredone;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  restored;
  logic                                      busy;
  logic                                      error;

  modport master (
    output restorestart, sorted_in, positions_in,
    input  restoredone, restored, busy, error
  );

  modport slave (
    input  restorestart, sorted_in, positions_in,
    output restoredone, restored, busy, error
  );
endinterface

// File: rtl/permute_restore.sv
// Scatters a sorted list back to original order, one entry per clock; done pulses N+1 cycles after start.
// No backpressure: starts arriving while busy (or in the FINISH cycle) are dropped, not queued.
module permute_restore #(
  parameter int INPUTVALS      = 16,
  parameter int INPUTBITWIDTHS = 32
) (
  input logic          clk,
  input logic          reset,
  permute_restore_if.slave bus
);
  localparam int N  = INPUTVALS;
  localparam int W  = INPUTBITWIDTHS;
  localparam int PW = $clog2(N) + 1;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    FINISH  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [N-1:0][W-1:0]    val_q;
  logic [N-1:0][PW-1:0]   pos_q;
  logic [N-1:0][W-1:0]    restored_q;
  logic [N-1:0]           seen_q;
  logic [IW-1:0]          idx_q;
  logic                   done_q;
  logic                   error_q;

  logic [PW-1:0]          p;
  logic [IW-1:0]          p_idx;
  logic                   p_ok;
  logic                   last;
  logic                   load;
  logic                   scatter_wr;
  logic                   scatter_bad;
  logic                   finish;
  logic                   bad_state;

  always_comb begin
    p           = pos_q[idx_q];
    p_idx       = p[IW-1:0];
    // A position is usable only if in range and not already claimed (first write wins).
    p_ok        = (p < PW'(N)) && !seen_q[p_idx];
    last        = (idx_q == IW'(N - 1));
    state_d     = state_q;
    load        = 1'b0;
    scatter_wr  = 1'b0;
    scatter_bad = 1'b0;
    finish      = 1'b0;
    bad_state   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.restorestart) begin
          load    = 1'b1;
          state_d = SCATTER;
        end
      end
      SCATTER: begin
        scatter_wr  = p_ok;
        scatter_bad = !p_ok;
        if (last) state_d = FINISH;
      end
      FINISH: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        bad_state = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      val_q      <= '0;
      pos_q      <= '0;
      restored_q <= '0;
      seen_q     <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      if (load) begin
        val_q      <= bus.sorted_in;
        pos_q      <= bus.positions_in;
        restored_q <= '0;
        seen_q     <= '0;
        error_q    <= 1'b0;
        idx_q      <= '0;
      end
      if (state_q == SCATTER) idx_q <= idx_q + IW'(1);
      if (scatter_wr) begin
        restored_q[p_idx] <= val_q[idx_q];
        seen_q[p_idx]     <= 1'b1;
      end
      // Duplicates and out-of-range entries flag during scatter; missing indices at finish.
      if (scatter_bad || bad_state || (finish && !(&seen_q))) error_q <= 1'b1;
    end
  end

  assign bus.restoredone = done_q;
  assign bus.restored    = restored_q;
  assign bus.busy        = (state_q == SCATTER) || (state_q == FINISH);
  assign bus.error       = error_q;
endmodule

// File: tb/tb_permute_restore.sv
// Directed bench for permute_restore (N=4, W=8) with a queue scoreboard checked by a done monitor.
module tb_permute_restore;
  localparam int N = 4;
  localparam int W = 8;
  localparam int PW = $clog2(N) + 1;

  typedef logic [N-1:0][W-1:0]  vec_t;
  typedef logic [N-1:0][PW-1:0] pvec_t;
  typedef struct {
    vec_t r;
    logic e;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sbq[$];
  exp_t mon_e;
  int   lat;
  int   bcnt;

  permute_restore_if #(.INPUTVALS(N), .INPUTBITWIDTHS(W)) bus ();

  permute_restore #(.INPUTVALS(N), .INPUTBITWIDTHS(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic [W-1:0] a0, a1, a2, a3);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    return v;
  endfunction

  function automatic pvec_t mkp(input logic [PW-1:0] a0, a1, a2, a3);
    pvec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive a start for one cycle; inputs are scrambled after the sampling edge to prove latching.
  task automatic start_op(input vec_t v, input pvec_t p, input vec_t er, input logic ee, input bit push);
    exp_t e;
    @(negedge clk);
    bus.sorted_in    = v;
    bus.positions_in = p;
    bus.restorestart = 1'b1;
    if (push) begin
      e.r = er;
      e.e = ee;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.restorestart = 1'b0;
    bus.sorted_in    = ~v;
    bus.positions_in = ~p;
  endtask

  // Counts edges after the accepting edge until done, and cycles with busy high.
  task automatic wait_done(output int l, output int b);
    bit got;
    got = 0;
    l = 0;
    b = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.busy) b++;
      if (bus.restoredone) got = 1;
      else begin
        @(posedge clk);
        l++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=restoredone");
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.restoredone) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          mon_e = sbq.pop_front();
          chk("restored", bus.restored, mon_e.r);
          chk("error_at_done", {31'd0, bus.error}, {31'd0, mon_e.e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t  orig;
    vec_t  sv;
    pvec_t pv;
    int    perm[N];
    int    tmp;

    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.restorestart = 1'b0;
    bus.sorted_in    = '0;
    bus.positions_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'd0, bus.restoredone}, 32'd0);
    chk("rst_restored", bus.restored, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_error", {31'd0, bus.error}, 32'd0);
    reset = 1'b1;

    // Identity; done appears after N+1 edges past the accepting edge.
    start_op(mkv(10, 20, 30, 40), mkp(0, 1, 2, 3), mkv(10, 20, 30, 40), 1'b0, 1);
    wait_done(lat, bcnt);
    chk("latency", lat, N + 1);

    // Reverse; busy spans N scatter cycles plus the finish cycle.
    start_op(mkv(1, 2, 3, 4), mkp(3, 2, 1, 0), mkv(4, 3, 2, 1), 1'b0, 1);
    wait_done(lat, bcnt);
    chk("busy_cycles", bcnt, N + 1);
    repeat (3) @(negedge clk);
    chk("restored_hold", bus.restored, mkv(4, 3, 2, 1));

    // Duplicate position: first write wins, index 1 left at zero.
    start_op(mkv(5, 6, 7, 8), mkp(0, 2, 2, 3), mkv(5, 0, 6, 8), 1'b1, 1);
    wait_done(lat, bcnt);

    // Out-of-range position.
    start_op(mkv(5, 6, 7, 8), mkp(0, 1, 2, 7), mkv(5, 6, 7, 0), 1'b1, 1);
    wait_done(lat, bcnt);
    chk("error_sticky", {31'd0, bus.error}, 32'd1);

    // A good start clears error as soon as it is accepted.
    start_op(mkv(9, 8, 7, 6), mkp(1, 0, 3, 2), mkv(8, 9, 6, 7), 1'b0, 1);
    @(negedge clk);
    chk("error_cleared", {31'd0, bus.error}, 32'd0);
    wait_done(lat, bcnt);

    // Reset during scatter at idx 2: abandoned, no done pulse.
    start_op(mkv(11, 22, 33, 44), mkp(0, 1, 2, 3), '0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_restored", bus.restored, 32'd0);
    chk("midrst_done", {31'd0, bus.restoredone}, 32'd0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    start_op(mkv(11, 22, 33, 44), mkp(2, 3, 0, 1), mkv(33, 44, 11, 22), 1'b0, 1);
    wait_done(lat, bcnt);
    chk("post_rst_latency", lat, N + 1);

    // Start pulse while busy is dropped; the monitor flags any second done.
    start_op(mkv(1, 2, 3, 4), mkp(0, 1, 2, 3), mkv(1, 2, 3, 4), 1'b0, 1);
    @(negedge clk);
    bus.sorted_in    = mkv(99, 98, 97, 96);
    bus.positions_in = mkp(3, 2, 1, 0);
    bus.restorestart = 1'b1;
    @(negedge clk);
    bus.restorestart = 1'b0;
    wait_done(lat, bcnt);
    repeat (10) @(negedge clk);

    // Random permutations: original list must come back unchanged.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < N; i++) begin
        orig[i] = W'($urandom);
        perm[i] = i;
      end
      for (int i = N - 1; i > 0; i--) begin
        int j;
        j = $urandom_range(i, 0);
        tmp = perm[i];
        perm[i] = perm[j];
        perm[j] = tmp;
      end
      for (int i = 0; i < N; i++) begin
        sv[i] = orig[perm[i]];
        pv[i] = PW'(perm[i]);
      end
      start_op(sv, pv, orig, 1'b0, 1);
      wait_done(lat, bcnt);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
